stft_frame_ctrl: RTL and testbench

Sequencer for the STFT input delay line, a bank of WIN enable/clear data registers.
- Generates the per-sample load enable and the bank clear for that bank.
- Tracks window fill and hop progress.
- Hands each completed window to the downstream FFT with a valid/ready handshake, back-pressuring the sample source meanwhile.
- Sits between the radar ADC sample stream and the FFT stage.

---
 rtl/stft_frame_ctrl_if.sv | 27 ++
 rtl/stft_frame_ctrl.sv | 113 +++++++++++
 tb/tb_stft_frame_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/stft_frame_ctrl_if.sv
// Handshake bundle between the STFT frame sequencer and its surroundings:
// sample source controls, FFT handshake and register-bank controls.
interface stft_frame_ctrl_if #(
  parameter int IW = 8
);
  logic          iSTART;
  logic          iSTOP;
  logic          iVALID;
  logic          iFFT_RDY;
  logic          oREADY;
  logic          oEN;
  logic          oCLR;
  logic          oWIN_VALID;
  logic [IW-1:0] oWIN_IDX;
  logic          oBUSY;

  // Master is the environment (ADC source, FFT, host); slave is the sequencer.
  modport master (
    output iSTART, iSTOP, iVALID, iFFT_RDY,
    input  oREADY, oEN, oCLR, oWIN_VALID, oWIN_IDX, oBUSY
  );

  modport slave (
    input  iSTART, iSTOP, iVALID, iFFT_RDY,
    output oREADY, oEN, oCLR, oWIN_VALID, oWIN_IDX, oBUSY
  );
endinterface

// File: rtl/stft_frame_ctrl.sv
// STFT input delay-line sequencer: clears and fills a WIN-deep register bank,
// then alternates between presenting a window to the FFT and shifting in HOP samples.
module stft_frame_ctrl #(
  parameter int WIN = 64,
  parameter int HOP = 32,
  parameter int CW  = 7,
  parameter int IW  = 8
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  stft_frame_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CLR, FILL, WAIT, RUN} stateT;

  stateT         state;
  logic [CW-1:0] fillCnt;
  logic [CW-1:0] hopCnt;
  logic          ready;
  logic          clr;
  logic          winValid;
  logic [IW-1:0] winIdx;
  logic          busy;
  logic          accept;

  // The load enable is the only combinational output, so a sample is taken the
  // same cycle it is offered and drops instantly with ready (including on reset).
  assign accept         = bus.iVALID & ready;
  assign bus.oEN        = accept;
  assign bus.oREADY     = ready;
  assign bus.oCLR       = clr;
  assign bus.oWIN_VALID = winValid;
  assign bus.oWIN_IDX   = winIdx;
  assign bus.oBUSY      = busy;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state    <= IDLE;
      fillCnt  <= '0;
      hopCnt   <= '0;
      ready    <= 1'b0;
      clr      <= 1'b0;
      winValid <= 1'b0;
      winIdx   <= '0;
      busy     <= 1'b0;
    end else begin
      clr <= 1'b0;
      // Stop outranks everything; the clear pulse flushes any sample loaded this cycle.
      if (bus.iSTOP && (state != IDLE)) begin
        state    <= IDLE;
        ready    <= 1'b0;
        winValid <= 1'b0;
        clr      <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.iSTART) begin
              state <= CLR;
              clr   <= 1'b1;
              ready <= 1'b0;
              busy  <= 1'b1;
            end
          end
          CLR: begin
            fillCnt <= '0;
            hopCnt  <= '0;
            winIdx  <= '0;
            ready   <= 1'b1;
            state   <= FILL;
          end
          FILL: begin
            if (accept) begin
              if (fillCnt == CW'(WIN - 1)) begin
                state    <= WAIT;
                ready    <= 1'b0;
                winValid <= 1'b1;
              end else begin
                fillCnt <= fillCnt + CW'(1);
              end
            end
          end
          WAIT: begin
            if (bus.iFFT_RDY) begin
              state    <= RUN;
              hopCnt   <= '0;
              winIdx   <= winIdx + IW'(1);
              winValid <= 1'b0;
              ready    <= 1'b1;
            end
          end
          RUN: begin
            if (accept) begin
              if (hopCnt == CW'(HOP - 1)) begin
                state    <= WAIT;
                ready    <= 1'b0;
                winValid <= 1'b1;
              end else begin
                hopCnt <= hopCnt + CW'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stft_frame_ctrl.sv
// Directed bench for stft_frame_ctrl (WIN=8, HOP=4, IW=2): a scoreboard of
// expected window index and sample count is checked whenever a window is presented.
module tb_stft_frame_ctrl;

  localparam int WIN = 8;
  localparam int HOP = 4;
  localparam int CW  = 4;
  localparam int IW  = 2;

  logic iCLK  = 1'b0;
  logic iRSTn = 1'b0;

  stft_frame_ctrl_if #(.IW(IW)) bus ();

  stft_frame_ctrl #(.WIN(WIN), .HOP(HOP), .CW(CW), .IW(IW)) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  int passCount  = 0;
  int checkCount = 0;
  int enCount    = 0;
  int expIdx     = 0;
  int idxQ[$];
  int cntQ[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Count load enables for the current cycle, then advance one clock.
  task automatic cycle();
    #1;
    if (bus.oEN) enCount++;
    @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input logic valid, input logic fftRdy);
    bus.iSTART   = start;
    bus.iSTOP    = stop;
    bus.iVALID   = valid;
    bus.iFFT_RDY = fftRdy;
  endtask

  task automatic expectWindow(input int idx, input int cnt);
    idxQ.push_back(idx % (1 << IW));
    cntQ.push_back(cnt);
  endtask

  task automatic popWindow(input string tag);
    int eIdx;
    int eCnt;
    checkOutput({tag, "_valid"}, int'(bus.oWIN_VALID), 1);
    if (idxQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 0, 1);
    end else begin
      eIdx = idxQ.pop_front();
      eCnt = cntQ.pop_front();
      checkOutput({tag, "_idx"}, int'(bus.oWIN_IDX), eIdx);
      checkOutput({tag, "_samples"}, enCount, eCnt);
      checkOutput({tag, "_readyLow"}, int'(bus.oREADY), 0);
    end
    enCount = 0;
  endtask

  task automatic waitWindow(input string tag);
    for (int i = 0; i < 100 && !bus.oWIN_VALID; i++) cycle();
    popWindow(tag);
  endtask

  task automatic handshake(input string tag);
    bus.iFFT_RDY = 1'b1;
    cycle();
    bus.iFFT_RDY = 1'b0;
    checkOutput({tag, "_validDrop"}, int'(bus.oWIN_VALID), 0);
    checkOutput({tag, "_readyRun"}, int'(bus.oREADY), 1);
    expIdx++;
    expectWindow(expIdx, HOP);
  endtask

  task automatic startFrame(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput({tag, "_clr"}, int'(bus.oCLR), 1);
    checkOutput({tag, "_clrReady"}, int'(bus.oREADY), 0);
    checkOutput({tag, "_busy"}, int'(bus.oBUSY), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput({tag, "_clrOnce"}, int'(bus.oCLR), 0);
    checkOutput({tag, "_fillReady"}, int'(bus.oREADY), 1);
    enCount = 0;
    expIdx  = 0;
    expectWindow(0, WIN);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge iCLK);
    #1;
    checkOutput("rstReady", int'(bus.oREADY), 0);
    checkOutput("rstEn", int'(bus.oEN), 0);
    checkOutput("rstClr", int'(bus.oCLR), 0);
    checkOutput("rstWinValid", int'(bus.oWIN_VALID), 0);
    checkOutput("rstIdx", int'(bus.oWIN_IDX), 0);
    checkOutput("rstBusy", int'(bus.oBUSY), 0);
    iRSTn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Initial fill followed by three hops.
    startFrame("fill0");
    bus.iVALID = 1'b1;
    waitWindow("win0");
    for (int w = 1; w <= 3; w++) begin
      handshake("hs");
      waitWindow("hop");
    end

    // FFT back-pressure while the source keeps offering samples.
    for (int k = 0; k < 20; k++) begin
      cycle();
      checkOutput("bpValid", int'(bus.oWIN_VALID), 1);
    end
    checkOutput("bpNoLoad", enCount, 0);
    handshake("bpRelease");
    waitWindow("wrap");

    // Asynchronous reset in the middle of a hop.
    handshake("preRst");
    cycle();
    cycle();
    checkOutput("runEnHigh", int'(bus.oEN), 1);
    iRSTn = 1'b0;
    #1;
    checkOutput("asyncReady", int'(bus.oREADY), 0);
    checkOutput("asyncEn", int'(bus.oEN), 0);
    checkOutput("asyncBusy", int'(bus.oBUSY), 0);
    checkOutput("asyncIdx", int'(bus.oWIN_IDX), 0);
    idxQ.delete();
    cntQ.delete();
    @(posedge iCLK);
    #1;
    iRSTn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();

    // Bursty source during fill.
    startFrame("burst");
    for (int k = 0; k < 100 && !bus.oWIN_VALID; k++) begin
      bus.iVALID = (k % 3 == 0);
      cycle();
    end
    popWindow("burstWin");

    // Stop from WAIT, then a no-op stop in IDLE.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    cycle();
    checkOutput("stopWaitClr", int'(bus.oCLR), 1);
    checkOutput("stopWaitValid", int'(bus.oWIN_VALID), 0);
    checkOutput("stopWaitBusy", int'(bus.oBUSY), 0);
    cycle();
    checkOutput("stopIdleNoClr", int'(bus.oCLR), 0);
    checkOutput("stopIdleBusy", int'(bus.oBUSY), 0);
    idxQ.delete();
    cntQ.delete();

    // Stop mid-fill together with start and a sample.
    startFrame("stopFill");
    bus.iVALID = 1'b1;
    repeat (5) cycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("stopEn", int'(bus.oEN), 1);
    cycle();
    checkOutput("stopSamples", enCount, 6);
    checkOutput("stopClr", int'(bus.oCLR), 1);
    checkOutput("stopReady", int'(bus.oREADY), 0);
    checkOutput("stopBusy", int'(bus.oBUSY), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("stopStaysIdle", int'(bus.oBUSY), 0);
    checkOutput("stopClrOnce", int'(bus.oCLR), 0);
    idxQ.delete();
    cntQ.delete();

    startFrame("restart");
    bus.iVALID = 1'b1;
    waitWindow("restartWin");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
